// File: rtl/frame_scheduler_if.sv
// Window-stage handshake between the frame scheduler (master) and the Hamming window (slave).
interface frame_scheduler_if #(
    parameter int Q_IN = 15
);
    logic                 win_request;
    logic                 win_valid_out;
    logic                 win_valid_packet;
    logic                 win_valid_in;
    logic signed [Q_IN:0] win_data;

    modport master (
        input  win_request,
        input  win_valid_out,
        output win_valid_packet,
        output win_valid_in,
        output win_data
    );

    modport slave (
        output win_request,
        output win_valid_out,
        input  win_valid_packet,
        input  win_valid_in,
        input  win_data
    );
endinterface

// File: rtl/frame_scheduler.sv
// Buffers audio samples in an N-deep circular RAM and feeds overlapping N-sample frames,
// oldest first, to the Hamming window stage over its request/strobe handshake.
module frame_scheduler #(
    parameter int Q_IN = 15,
    parameter int N    = 256,
    parameter int HOP  = 128,
    parameter int AW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic signed [Q_IN:0] sample_in,
    frame_scheduler_if.master    win,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FEED,
        DRAIN
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [AW-1:0] HOP_LAST  = AW'(HOP - 1);
    localparam logic [AW:0]   FRAME_LEN = (AW + 1)'(N);

    state_t state, state_next;

    logic signed [Q_IN:0] ram [N];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill_cnt;
    logic [AW-1:0] hop_cnt;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   idx;
    logic [AW:0]   idx_inc;
    logic [AW:0]   out_cnt;
    logic          primed;
    logic          req_q;
    logic          vo_q;
    logic          trigger;
    logic          req_rise;
    logic          vo_fall;
    logic          last_strobe;
    logic          strobe_next;
    logic          frame_done;

    // The first trigger waits for a full RAM; afterwards one fires every HOP writes.
    assign trigger     = sample_valid & (primed ? (hop_cnt == HOP_LAST) : (fill_cnt == LAST_ADDR));
    assign req_rise    = win.win_request & ~req_q;
    assign vo_fall     = ~win.win_valid_out & vo_q;
    assign idx_inc     = idx + 1'b1;
    assign rd_addr     = start_addr + idx_inc[AW-1:0];
    assign last_strobe = win.win_valid_in && (idx_inc == FRAME_LEN);

    always_ff @(posedge clk) begin
        if (sample_valid) begin
            ram[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next           = state;
        win.win_valid_packet = 1'b0;
        busy                 = (state != IDLE);
        strobe_next          = 1'b0;
        frame_done           = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                win.win_valid_packet = 1'b1;
                state_next           = FEED;
            end
            FEED: begin
                // A rising edge seen while the final strobe is out must not produce an extra one.
                strobe_next = req_rise && !last_strobe;
                if (last_strobe) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt == FRAME_LEN) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            fill_cnt         <= '0;
            hop_cnt          <= '0;
            primed           <= 1'b0;
            req_q            <= 1'b0;
            vo_q             <= 1'b0;
            start_addr       <= '0;
            idx              <= '0;
            out_cnt          <= '0;
            win.win_valid_in <= 1'b0;
            win.win_data     <= '0;
            frame_count      <= '0;
            overrun          <= 1'b0;
        end else begin
            req_q            <= win.win_request;
            vo_q             <= win.win_valid_out;
            win.win_valid_in <= strobe_next;

            if (sample_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!primed) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (trigger) begin
                        primed <= 1'b1;
                    end
                end else begin
                    hop_cnt <= trigger ? '0 : hop_cnt + 1'b1;
                end
            end

            // The slot about to be overwritten next holds the oldest sample of the frame.
            if (trigger) begin
                if (state == IDLE) begin
                    start_addr <= wr_ptr + 1'b1;
                    idx        <= '0;
                    out_cnt    <= '0;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if (state == ARM) begin
                win.win_data <= ram[start_addr];
            end

            if (state == FEED && win.win_valid_in) begin
                idx          <= idx_inc;
                win.win_data <= ram[rd_addr];
            end

            if ((state == FEED || state == DRAIN) && vo_fall) begin
                out_cnt <= out_cnt + 1'b1;
            end

            if (frame_done) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule
